// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the decode and execute stages of the RV32 pipeline:
//   opcode constants, ALU control codes, result-source codes, immediate
//   formats, the decoded control bundle and the ID/EX pipeline register
//   layout, plus two small decode helpers.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   // Major opcodes (instruction bits [6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLTU = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC1 = 2'b10
   } result_src_e;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J,
      IMM_U
   } imm_type_e;

   // Flush sequencing: one extra bubble is owed after a taken branch/jump.
   typedef enum logic {
      FL_RUN,
      FL_SQUASH
   } flush_state_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        alu_src;
      result_src_e result_src;
      alu_ctrl_e   alu_control;
      imm_type_e   imm_type;
   } ctrl_t;

   // All-zero controls; also what an unknown opcode decodes to.
   localparam ctrl_t CTRL_BUBBLE = '{
      reg_write:   1'b0,
      mem_write:   1'b0,
      branch:      1'b0,
      jump:        1'b0,
      alu_src:     1'b0,
      result_src:  RES_ALU,
      alu_control: ALU_ADD,
      imm_type:    IMM_I
   };

   typedef struct packed {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            alu_src;
      result_src_e     result_src;
      alu_ctrl_e       alu_control;
      logic [2:0]      funct3;
   } id_ex_t;

   // Sign-extended immediate for the given format. Takes ir[31:7]; the
   // opcode bits never contribute to an immediate.
   function automatic logic [XLEN-1:0] gen_imm(input logic [31:7] ir,
                                               input imm_type_e   t);
      logic [XLEN-1:0] imm;
      case (t)
         IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         IMM_U:   imm = {ir[31:12], 12'b0};
         default: imm = {{20{ir[31]}}, ir[31:20]};
      endcase
      return imm;
   endfunction

   // ALU operation from funct3/funct7[5]. funct7[5] means SUB only for
   // register-register ops; for shifts-right it selects arithmetic in both
   // the R and I forms (SRA/SRAI).
   function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3,
                                            input logic       funct7_b5,
                                            input logic       is_r);
      alu_ctrl_e op;
      case (funct3)
         3'b000:  op = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/register_file.sv
// register_file
//   32 x 32-bit integer register file.
//   clk, rst      : clock, asynchronous active-high reset (clears all entries)
//   ra1, ra2      : asynchronous read addresses
//   rd1, rd2      : read data; x0 always reads 0
//   we, wa, wd    : synchronous write port; writes to x0 are dropped
//   A read whose address matches an enabled, non-x0 write in the same cycle
//   returns the write data (write-through), so decode sees writeback results
//   without an extra forwarding stage.
module register_file
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_active;

   assign wr_active = we && (wa != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_active) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = regs[ra1];
      if (ra1 == 5'd0) begin
         rd1 = '0;
      end else if (wr_active && (wa == ra1)) begin
         rd1 = wd;
      end
   end

   always_comb begin
      rd2 = regs[ra2];
      if (ra2 == 5'd0) begin
         rd2 = '0;
      end else if (wr_active && (wa == ra2)) begin
         rd2 = wd;
      end
   end

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode
//   RV32 decode stage with the ID/EX pipeline register.
//   clk, rst            : clock, asynchronous active-high reset
//   IF_ID_IR, IF_ID_PC  : instruction and its word-addressed PC from fetch
//   PCSrcE              : taken branch/jump in execute; flushes wrong path
//   RegWriteW/RdW/ResultW : writeback port into the register file
//   ID_EX_*             : registered operands, immediate, indices, controls
//   Every ID_EX output comes straight from a flop; the stage has one cycle
//   of latency and no stall input.
//   Flush: a taken PCSrcE leaves two wrong-path instructions behind it (the
//   one in decode now and the one in fetch). The edge with PCSrcE=1 loads a
//   bubble and enters FL_SQUASH; the next edge loads a second bubble and
//   returns to FL_RUN unless PCSrcE is asserted again.
module instruction_decode
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     IF_ID_IR,
   input  logic [31:0]     IF_ID_PC,
   input  logic            PCSrcE,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [31:0]     ResultW,
   output logic [31:0]     ID_EX_RD1,
   output logic [31:0]     ID_EX_RD2,
   output logic [31:0]     ID_EX_Imm,
   output logic [31:0]     ID_EX_PC,
   output logic [4:0]      ID_EX_Rs1,
   output logic [4:0]      ID_EX_Rs2,
   output logic [4:0]      ID_EX_Rd,
   output logic            ID_EX_RegWrite,
   output logic            ID_EX_MemWrite,
   output logic            ID_EX_Branch,
   output logic            ID_EX_Jump,
   output logic            ID_EX_ALUSrc,
   output logic [1:0]      ID_EX_ResultSrc,
   output logic [3:0]      ID_EX_ALUControl,
   output logic [2:0]      ID_EX_funct3
);

   logic [6:0]   opcode;
   logic [2:0]   funct3;
   logic         funct7_b5;
   logic [4:0]   rs1;
   logic [4:0]   rs2;
   logic [4:0]   rd;
   logic [31:0]  rf_rd1;
   logic [31:0]  rf_rd2;
   ctrl_t        ctrl;
   id_ex_t       id_ex_d;
   id_ex_t       id_ex_q;
   flush_state_e flush_state;

   assign opcode    = IF_ID_IR[6:0];
   assign rd        = IF_ID_IR[11:7];
   assign funct3    = IF_ID_IR[14:12];
   assign rs1       = IF_ID_IR[19:15];
   assign rs2       = IF_ID_IR[24:20];
   assign funct7_b5 = IF_ID_IR[30];

   register_file u_register_file (
      .clk (clk),
      .rst (rst),
      .ra1 (rs1),
      .ra2 (rs2),
      .rd1 (rf_rd1),
      .rd2 (rf_rd2),
      .we  (RegWriteW),
      .wa  (RdW),
      .wd  (ResultW)
   );

   // Main control decode. Unknown opcodes keep CTRL_BUBBLE so nothing
   // downstream writes state, while the data fields are still captured.
   always_comb begin
      ctrl = CTRL_BUBBLE;
      case (opcode)
         OP_R: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_control = alu_decode(funct3, funct7_b5, 1'b1);
         end
         OP_I_ALU: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src     = 1'b1;
            ctrl.alu_control = alu_decode(funct3, funct7_b5, 1'b0);
         end
         OP_LOAD: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src     = 1'b1;
            ctrl.result_src  = RES_MEM;
         end
         OP_STORE: begin
            ctrl.mem_write   = 1'b1;
            ctrl.alu_src     = 1'b1;
            ctrl.imm_type    = IMM_S;
         end
         OP_BRANCH: begin
            ctrl.branch      = 1'b1;
            ctrl.alu_control = ALU_SUB;
            ctrl.imm_type    = IMM_B;
         end
         OP_JAL: begin
            ctrl.jump        = 1'b1;
            ctrl.reg_write   = 1'b1;
            ctrl.result_src  = RES_PC1;
            ctrl.imm_type    = IMM_J;
         end
         OP_JALR: begin
            // Target is rs1 + imm, so the ALU takes the immediate.
            ctrl.jump        = 1'b1;
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src     = 1'b1;
            ctrl.result_src  = RES_PC1;
         end
         OP_LUI, OP_AUIPC: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src     = 1'b1;
            ctrl.imm_type    = IMM_U;
         end
         default: ;
      endcase
   end

   always_comb begin
      id_ex_d             = '0;
      id_ex_d.rd1         = rf_rd1;
      id_ex_d.rd2         = rf_rd2;
      id_ex_d.imm         = gen_imm(IF_ID_IR[31:7], ctrl.imm_type);
      id_ex_d.pc          = IF_ID_PC;
      id_ex_d.rs1         = rs1;
      id_ex_d.rs2         = rs2;
      id_ex_d.rd          = rd;
      id_ex_d.reg_write   = ctrl.reg_write;
      id_ex_d.mem_write   = ctrl.mem_write;
      id_ex_d.branch      = ctrl.branch;
      id_ex_d.jump        = ctrl.jump;
      id_ex_d.alu_src     = ctrl.alu_src;
      id_ex_d.result_src  = ctrl.result_src;
      id_ex_d.alu_control = ctrl.alu_control;
      id_ex_d.funct3      = funct3;
   end

   // Pipeline register and flush sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_q     <= '0;
         flush_state <= FL_RUN;
      end else if (PCSrcE) begin
         id_ex_q     <= '0;
         flush_state <= FL_SQUASH;
      end else if (flush_state == FL_SQUASH) begin
         id_ex_q     <= '0;
         flush_state <= FL_RUN;
      end else begin
         id_ex_q     <= id_ex_d;
      end
   end

   assign ID_EX_RD1        = id_ex_q.rd1;
   assign ID_EX_RD2        = id_ex_q.rd2;
   assign ID_EX_Imm        = id_ex_q.imm;
   assign ID_EX_PC         = id_ex_q.pc;
   assign ID_EX_Rs1        = id_ex_q.rs1;
   assign ID_EX_Rs2        = id_ex_q.rs2;
   assign ID_EX_Rd         = id_ex_q.rd;
   assign ID_EX_RegWrite   = id_ex_q.reg_write;
   assign ID_EX_MemWrite   = id_ex_q.mem_write;
   assign ID_EX_Branch     = id_ex_q.branch;
   assign ID_EX_Jump       = id_ex_q.jump;
   assign ID_EX_ALUSrc     = id_ex_q.alu_src;
   assign ID_EX_ResultSrc  = id_ex_q.result_src;
   assign ID_EX_ALUControl = id_ex_q.alu_control;
   assign ID_EX_funct3     = id_ex_q.funct3;

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode
//   Randomized and directed stimulus for instruction_decode. Each driven
//   cycle pushes the reference model's expected ID/EX contents into exp_q;
//   a monitor pops and compares one entry after every rising edge.
module tb_instruction_decode;

   localparam int VW = 157;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst;
   logic [31:0] IF_ID_IR;
   logic [31:0] IF_ID_PC;
   logic        PCSrcE;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic [31:0] ID_EX_RD1, ID_EX_RD2, ID_EX_Imm, ID_EX_PC;
   logic [4:0]  ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
   logic        ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_Branch, ID_EX_Jump, ID_EX_ALUSrc;
   logic [1:0]  ID_EX_ResultSrc;
   logic [3:0]  ID_EX_ALUControl;
   logic [2:0]  ID_EX_funct3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   instruction_decode dut (
      .clk              (clk),
      .rst              (rst),
      .IF_ID_IR         (IF_ID_IR),
      .IF_ID_PC         (IF_ID_PC),
      .PCSrcE           (PCSrcE),
      .RegWriteW        (RegWriteW),
      .RdW              (RdW),
      .ResultW          (ResultW),
      .ID_EX_RD1        (ID_EX_RD1),
      .ID_EX_RD2        (ID_EX_RD2),
      .ID_EX_Imm        (ID_EX_Imm),
      .ID_EX_PC         (ID_EX_PC),
      .ID_EX_Rs1        (ID_EX_Rs1),
      .ID_EX_Rs2        (ID_EX_Rs2),
      .ID_EX_Rd         (ID_EX_Rd),
      .ID_EX_RegWrite   (ID_EX_RegWrite),
      .ID_EX_MemWrite   (ID_EX_MemWrite),
      .ID_EX_Branch     (ID_EX_Branch),
      .ID_EX_Jump       (ID_EX_Jump),
      .ID_EX_ALUSrc     (ID_EX_ALUSrc),
      .ID_EX_ResultSrc  (ID_EX_ResultSrc),
      .ID_EX_ALUControl (ID_EX_ALUControl),
      .ID_EX_funct3     (ID_EX_funct3)
   );

   logic [VW-1:0] act;
   assign act = {ID_EX_RD1, ID_EX_RD2, ID_EX_Imm, ID_EX_PC,
                 ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd,
                 ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_Branch, ID_EX_Jump, ID_EX_ALUSrc,
                 ID_EX_ResultSrc, ID_EX_ALUControl, ID_EX_funct3};

   // ---------------- reference model ----------------
   logic [VW-1:0] exp_q[$];
   logic [31:0]   m_regs [32];
   bit            m_squash;
   int            tests_run;
   int            tests_failed;
   string         tname;

   // ALU code by {funct7[5], funct3} for register-register instructions:
   // ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6 SLL=7 SRL=8 SRA=9
   localparam logic [3:0] ALU_TAB [16] = '{
      4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2,
      4'd1, 4'd7, 4'd5, 4'd6, 4'd4, 4'd9, 4'd3, 4'd2
   };

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (RegWriteW && RdW == idx) return ResultW;
      return m_regs[idx];
   endfunction

   function automatic logic [VW-1:0] model(input logic [31:0] ir, pc, a, b);
      logic [6:0]        op;
      logic [2:0]        f3;
      logic              f7b;
      logic signed [11:0] s12;
      logic signed [12:0] s13;
      logic signed [20:0] s21;
      logic [31:0]       imm;
      logic              rw, mw, br, jp, as;
      logic [1:0]        rs;
      logic [3:0]        alu;
      op  = ir[6:0];
      f3  = ir[14:12];
      f7b = ir[30];
      rw = 0; mw = 0; br = 0; jp = 0; as = 0; rs = 2'd0; alu = 4'd0;
      s12 = ir[31:20];
      imm = int'(s12);
      case (op)
         7'b0110011: begin rw = 1; alu = ALU_TAB[{f7b, f3}]; end
         7'b0010011: begin rw = 1; as = 1; alu = ALU_TAB[{(f3 == 3'd0) ? 1'b0 : f7b, f3}]; end
         7'b0000011: begin rw = 1; as = 1; rs = 2'b01; end
         7'b0100011: begin
            mw = 1; as = 1;
            s12 = {ir[31:25], ir[11:7]};
            imm = int'(s12);
         end
         7'b1100011: begin
            br = 1; alu = 4'd1;
            s13 = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            imm = int'(s13);
         end
         7'b1101111: begin
            jp = 1; rw = 1; rs = 2'b10;
            s21 = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            imm = int'(s21);
         end
         7'b1100111: begin jp = 1; rw = 1; as = 1; rs = 2'b10; end
         7'b0110111, 7'b0010111: begin rw = 1; as = 1; imm = ir & 32'hFFFF_F000; end
         default: ;
      endcase
      return {a, b, imm, pc, ir[19:15], ir[24:20], ir[11:7],
              rw, mw, br, jp, as, rs, alu, f3};
   endfunction

   // ---------------- driver ----------------
   task automatic step();
      logic [VW-1:0] e;
      logic [31:0]   a, b;
      a = m_read(IF_ID_IR[19:15]);
      b = m_read(IF_ID_IR[24:20]);
      if (PCSrcE) begin
         e = '0;
         m_squash = 1;
      end else if (m_squash) begin
         e = '0;
         m_squash = 0;
      end else begin
         e = model(IF_ID_IR, IF_ID_PC, a, b);
      end
      if (RegWriteW && RdW != 5'd0) m_regs[RdW] = ResultW;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic pcs,
                        input logic we, input logic [4:0] rd, input logic [31:0] res);
      IF_ID_IR  = ir;
      IF_ID_PC  = pc;
      PCSrcE    = pcs;
      RegWriteW = we;
      RdW       = rd;
      ResultW   = res;
      step();
   endtask

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      tests_run++;
      if (a !== e) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_squash = 0;
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [VW-1:0] mon_e;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            tests_run++;
            if (act !== mon_e) begin
               tests_failed++;
               $display("FAIL %s: got %h expected %h", tname, act, mon_e);
            end
         end
      end
   end

   // Drives pattern bits pcs_pat over 8 add instructions and checks which
   // cycles come out as bubbles against the hand-derived bub_pat.
   task automatic flush_seq(input string name, input logic [7:0] pcs_pat,
                            input logic [7:0] bub_pat, input logic [31:0] pc0);
      for (int k = 0; k < 8; k++) begin
         drive(32'h002081B3, pc0 + 32'(k), pcs_pat[k], 1'b0, 5'd0, 32'd0);
         check($sformatf("%s_regwrite_%0d", name, k), {31'd0, ID_EX_RegWrite}, {31'd0, !bub_pat[k]});
         check($sformatf("%s_pc_%0d", name, k), ID_EX_PC, bub_pat[k] ? 32'd0 : pc0 + 32'(k));
      end
   endtask

   // ---------------- main sequence ----------------
   localparam logic [6:0] OPS [12] = '{
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0001111, 7'b0110011
   };

   task automatic random_phase(input int n);
      logic [31:0] r, ir;
      logic [4:0]  rd;
      for (int i = 0; i < n; i++) begin
         r  = $urandom();
         ir = {r[31:7], OPS[$urandom_range(0, 11)]};
         rd = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) rd = ir[19:15];
         drive(ir, $urandom(), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), rd, $urandom());
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      tname = "reset";
      rst = 1'b1;
      IF_ID_IR = 32'h002081B3;
      IF_ID_PC = 32'd7;
      PCSrcE = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_rd1", ID_EX_RD1, 32'd0);
      check("reset_pc", ID_EX_PC, 32'd0);
      check("reset_ctrl", {19'd0, ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_Branch, ID_EX_Jump,
                           ID_EX_ALUSrc, ID_EX_ResultSrc, ID_EX_ALUControl, ID_EX_funct3}, 32'd0);
      rst = 1'b0;

      tname = "preload";
      for (int i = 1; i < 32; i++) drive(32'h00000033, 32'(i), 0, 1, 5'(i), $urandom());

      tname = "write_through";
      drive(32'h000280B3, 32'h40, 0, 1, 5'd5, 32'hDEADBEEF);
      check("wt_rd1", ID_EX_RD1, 32'hDEADBEEF);
      check("wt_aluctl", {28'd0, ID_EX_ALUControl}, 32'd0);
      check("wt_regwrite", {31'd0, ID_EX_RegWrite}, 32'd1);

      tname = "x0_protect";
      drive(32'h000000B3, 32'h41, 0, 1, 5'd0, 32'h12345678);
      check("x0_same_cycle", ID_EX_RD1, 32'd0);
      drive(32'h000000B3, 32'h42, 0, 0, 5'd0, 32'd0);
      check("x0_after_write", ID_EX_RD1, 32'd0);

      tname = "immediates";
      drive(32'hFE000EE3, 32'h43, 0, 0, 5'd0, 32'd0);
      check("beq_imm", ID_EX_Imm, 32'hFFFFFFFC);
      check("beq_branch", {31'd0, ID_EX_Branch}, 32'd1);
      check("beq_regwrite", {31'd0, ID_EX_RegWrite}, 32'd0);
      drive(32'h800000EF, 32'h44, 0, 0, 5'd0, 32'd0);
      check("jal_imm", ID_EX_Imm, 32'hFFF00000);
      check("jal_jump", {31'd0, ID_EX_Jump}, 32'd1);
      check("jal_resultsrc", {30'd0, ID_EX_ResultSrc}, 32'd2);

      tname = "flush_single";
      flush_seq("flush1", 8'b0000_0010, 8'b0000_0110, 32'd200);
      tname = "flush_double";
      flush_seq("flush2", 8'b0000_0110, 8'b0000_1110, 32'd300);

      tname = "random";
      random_phase(400);

      tname = "reset_in_squash";
      drive(32'h002081B3, 32'd500, 1, 0, 5'd0, 32'd0);
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_sq_pc", ID_EX_PC, 32'd0);
      check("rst_sq_rd1", ID_EX_RD1, 32'd0);
      check("rst_sq_ctrl", {27'd0, ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_Branch, ID_EX_Jump,
                            ID_EX_ALUSrc}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(32'h002081B3, 32'd501, 0, 0, 5'd0, 32'd0);
      check("post_rst_regwrite", {31'd0, ID_EX_RegWrite}, 32'd1);
      check("post_rst_pc", ID_EX_PC, 32'd501);

      tname = "random_tail";
      random_phase(60);

      @(negedge clk);
      if (exp_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameters: none; XLEN fixed at 32, register count fixed at 32.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 IF_ID_IR  in  32  instruction word from the fetch-stage pipeline register.
REQ-005 IF_ID_PC  in  32  word-addressed PC of IF_ID_IR.
REQ-006 PCSrcE  in  1  branch/jump taken in execute; triggers flush.
REQ-007 RegWriteW, RdW[4:0], ResultW[31:0]  in  writeback port: enable, destination, data.
REQ-008 ID_EX_RD1, ID_EX_RD2  out  32 each  registered source operands.
REQ-009 ID_EX_Imm  out  32  registered sign-extended immediate.
REQ-010 ID_EX_PC  out  32  registered copy of IF_ID_PC.
REQ-011 ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd  out  5 each  registered register indices.
REQ-012 ID_EX_RegWrite, ID_EX_MemWrite, ID_EX_Branch, ID_EX_Jump, ID_EX_ALUSrc  out  1 each  registered controls.
REQ-013 ID_EX_ResultSrc  out  2  00 ALU, 01 memory, 10 PC+1.
REQ-014 ID_EX_ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
REQ-015 ID_EX_funct3  out  3  registered funct3, for branch condition and load/store width.

Function
REQ-016 Latency SHALL be exactly one cycle: IF_ID_* presented in cycle n appear on ID_EX_* after edge n.
REQ-017 Register file: 32x32; x0 SHALL read 0 and ignore writes; write on the rising edge when RegWriteW=1 and RdW!=0.
REQ-018 Write-through: when RegWriteW=1, RdW!=0 and RdW equals rs1 or rs2, the matching read SHALL return ResultW in the same cycle.
REQ-019 Immediates: I {20{ir[31]},ir[31:20]}; S {20{ir[31]},ir[31:25],ir[11:7]}; B {19{ir[31]},ir[31],ir[7],ir[30:25],ir[11:8],0}; J {11{ir[31]},ir[31],ir[19:12],ir[20],ir[30:21],0}; U {ir[31:12],12'b0}.
REQ-020 Opcode decode: 0110011 R-type; 0010011 I-ALU; 0000011 load (ResultSrc 01, ALUSrc 1, ADD); 0100011 store (MemWrite 1, ALUSrc 1, ADD, RegWrite 0); 1100011 branch (Branch 1, SUB, RegWrite 0); 1101111 jal and 1100111 jalr (Jump 1, ResultSrc 10, RegWrite 1); 0110111 lui and 0010111 auipc (U immediate, ALUSrc 1).
REQ-021 ALUControl: funct3/funct7[5] select ADD/SUB/SRL/SRA for R-type; I-type ignores funct7[5] except for SRAI.
REQ-022 Unknown opcode SHALL produce a bubble: all control outputs 0, data fields still registered.
REQ-023 Flush: PCSrcE=1 at an edge SHALL load a bubble (all ID_EX outputs 0) and set internal flag squash.
REQ-024 squash=1 at the next edge SHALL load a second bubble and clear squash; together these remove both wrong-path instructions.
REQ-025 PCSrcE=1 while squash=1 SHALL load a bubble and keep squash=1.
REQ-026 All ID_EX_* outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-027 rst=1 SHALL immediately clear all ID_EX_* outputs, squash, and all 32 registers to 0.
REQ-028 Reset asserted mid-flush SHALL clear squash; the first edge after release decodes IF_ID_IR normally.

Structure
REQ-029 Opcode constants, ALUControl codes, and ResultSrc codes SHALL live in a shared package, riscv_pkg, together with the execute stage.
REQ-030 The register file SHALL be a sub-module, register_file: two asynchronous read ports, one synchronous write port, and write-through.

Verification
REQ-031 Write-through: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, IR=add x1,x5,x0 -> next edge ID_EX_RD1=0xDEADBEEF, ALUControl=0000, RegWrite=1.
REQ-032 x0 protection: write RdW=0 with 0x12345678, then read x0 -> ID_EX_RD1=0.
REQ-033 Immediate: IR=0xFE000EE3 (beq, offset -4) -> ID_EX_Imm=0xFFFFFFFC, Branch=1, RegWrite=0; IR=0x800000EF (jal) -> Imm=0xFFF00000, Jump=1, ResultSrc=10.
REQ-034 Flush: valid add instructions every cycle with PCSrcE=1 for one cycle -> exactly two consecutive bubbles, then normal decode.
REQ-035 Back-to-back flush: PCSrcE=1 for two cycles -> three consecutive bubbles.
REQ-036 Reset during squash: assert rst the cycle after PCSrcE -> all outputs 0; after release, the next instruction is decoded, not bubbled.
